// File: rtl/fp_norm_pkg.sv
// Shared types and constant helpers for the floating-point normaliser datapath.
// Used by fp_normalizer_pipe and lead_zero_count.
package fp_norm_pkg;

    // Width of a leading-zero count able to represent 0..sig_w inclusive.
    function automatic int lz_w(input int sig_w);
        return $clog2(sig_w + 1);
    endfunction

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } norm_flags_t;

    function automatic int unsigned exp_all_ones(input int exp_w);
        return (32'd1 << exp_w) - 32'd1;
    endfunction

endpackage

// File: rtl/lead_zero_count.sv
// Tree leading-zero counter: pads the input to a power of two and merges
// (valid, count) pairs level by level from the leaves up.
module lead_zero_count
    import fp_norm_pkg::*;
#(
    parameter int SIG_W = 24
) (
    input  logic [SIG_W-1:0]          data,
    output logic [lz_w(SIG_W)-1:0]    count,
    output logic                      all_zero
);

    localparam int CNT_W = lz_w(SIG_W);
    localparam int LVL   = (SIG_W > 1) ? $clog2(SIG_W) : 1;
    localparam int P     = 1 << LVL;
    localparam int TW    = LVL + 1;

    // Node 0 of each level is the most significant group; when its left half
    // holds a one, the count comes from the left, otherwise left size + right.
    function automatic logic [TW-1:0] tree_lz(input logic [SIG_W-1:0] d);
        logic [P-1:0]  pad;
        logic [TW-1:0] cnt [0:P-1];
        logic          vld [0:P-1];
        logic [TW-1:0] c_new;
        logic          v_new;
        pad = '0;
        pad[P-1 -: SIG_W] = d;
        for (int i = 0; i < P; i++) begin
            vld[i] = pad[P-1-i];
            cnt[i] = '0;
        end
        for (int l = 0; l < LVL; l++) begin
            for (int i = 0; i < (P >> (l + 1)); i++) begin
                if (vld[2*i])
                    c_new = cnt[2*i];
                else
                    c_new = cnt[2*i+1] + TW'(1 << l);
                v_new  = vld[2*i] | vld[2*i+1];
                cnt[i] = c_new;
                vld[i] = v_new;
            end
        end
        return cnt[0];
    endfunction

    always_comb begin
        all_zero = ~|data;
        count    = all_zero ? CNT_W'(SIG_W) : CNT_W'(tree_lz(data));
    end

endmodule

// File: rtl/fp_normalizer_pipe.sv
// Two-stage post-add normaliser: stage 1 captures the sum and its leading-zero
// count, stage 2 selects carry/zero/normal/underflow handling into the outputs.
module fp_normalizer_pipe
    import fp_norm_pkg::*;
#(
    parameter int SIG_W = 24,
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIG_W:0]   in_sig,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIG_W-1:0] out_sig,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_round,
    output logic             out_zero,
    output logic             out_underflow,
    output logic             out_overflow
);

    localparam int LZ_W = lz_w(SIG_W);
    localparam logic [EXP_W:0] EXP_ONES = (EXP_W+1)'(exp_all_ones(EXP_W));

    logic [LZ_W-1:0] lz_cnt;
    logic            lz_all_zero;

    lead_zero_count #(.SIG_W(SIG_W)) u_lzc (
        .data     (in_sig[SIG_W-1:0]),
        .count    (lz_cnt),
        .all_zero (lz_all_zero)
    );

    logic             s1_valid_q, s1_valid_d;
    logic [SIG_W:0]   s1_sig_q,   s1_sig_d;
    logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
    logic [LZ_W-1:0]  s1_lz_q,    s1_lz_d;
    logic             s1_zero_q,  s1_zero_d;

    logic             out_valid_q, out_valid_d;
    logic [SIG_W-1:0] out_sig_q,   out_sig_d;
    logic [EXP_W-1:0] out_exp_q,   out_exp_d;
    logic             out_round_q, out_round_d;
    norm_flags_t      flags_q,     flags_d;

    logic             s2_ready;
    logic             s1_load;
    logic             s2_load;

    logic [SIG_W-1:0] res_sig;
    logic [EXP_W-1:0] res_exp;
    logic             res_round;
    norm_flags_t      res_flags;
    logic [EXP_W:0]   exp_x;
    logic [EXP_W:0]   lz_x;

    // in_ready depends on out_ready combinationally; in_valid never reaches out_valid.
    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_ready;
        s1_load  = in_valid && in_ready;
        s2_load  = s1_valid_q && s2_ready;
    end

    always_comb begin
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_sig_d   = s1_sig_q;
        s1_exp_d   = s1_exp_q;
        s1_lz_d    = s1_lz_q;
        s1_zero_d  = s1_zero_q;
        if (s1_load) begin
            s1_sig_d  = in_sig;
            s1_exp_d  = in_exp;
            s1_lz_d   = lz_cnt;
            s1_zero_d = lz_all_zero;
        end
    end

    // Result mux; exponent math is one bit wider so nothing wraps.
    always_comb begin
        res_sig   = '0;
        res_exp   = '0;
        res_round = 1'b0;
        res_flags = '0;
        exp_x     = {1'b0, s1_exp_q};
        lz_x      = (EXP_W+1)'(s1_lz_q);
        if (s1_sig_q[SIG_W]) begin
            if (exp_x >= EXP_ONES - 1'b1) begin
                res_exp            = EXP_ONES[EXP_W-1:0];
                res_flags.overflow = 1'b1;
            end else begin
                res_sig   = s1_sig_q[SIG_W:1];
                res_round = s1_sig_q[0];
                res_exp   = EXP_W'(exp_x + 1'b1);
            end
        end else if (s1_zero_q) begin
            res_flags.zero = 1'b1;
        end else if (s1_lz_q == '0 || lz_x < exp_x) begin
            res_sig = s1_sig_q[SIG_W-1:0] << s1_lz_q;
            res_exp = EXP_W'(exp_x - lz_x);
        end else begin
            res_sig             = s1_sig_q[SIG_W-1:0] << s1_exp_q;
            res_flags.underflow = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
        out_sig_d   = out_sig_q;
        out_exp_d   = out_exp_q;
        out_round_d = out_round_q;
        flags_d     = flags_q;
        if (s2_load) begin
            out_sig_d   = res_sig;
            out_exp_d   = res_exp;
            out_round_d = res_round;
            flags_d     = res_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sig_q    <= '0;
            s1_exp_q    <= '0;
            s1_lz_q     <= '0;
            s1_zero_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sig_q   <= '0;
            out_exp_q   <= '0;
            out_round_q <= 1'b0;
            flags_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sig_q    <= s1_sig_d;
            s1_exp_q    <= s1_exp_d;
            s1_lz_q     <= s1_lz_d;
            s1_zero_q   <= s1_zero_d;
            out_valid_q <= out_valid_d;
            out_sig_q   <= out_sig_d;
            out_exp_q   <= out_exp_d;
            out_round_q <= out_round_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_sig       = out_sig_q;
    assign out_exp       = out_exp_q;
    assign out_round     = out_round_q;
    assign out_zero      = flags_q.zero;
    assign out_underflow = flags_q.underflow;
    assign out_overflow  = flags_q.overflow;

endmodule
